// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared types and constants for the ALU issue/hazard controller.
//   COP_W         : operation code width
//   MUL_COP_DEF   : default cop executed as a multi-cycle operation
//   FWD_*         : forwarding select encodings driven to alu_stage
//   ctrl_state_t  : issue FSM state type
//   age_to_sel    : maps a forwardable producer age to its select value
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

   localparam int unsigned COP_W = 4;
   localparam logic [COP_W-1:0] MUL_COP_DEF = 4'b0110;

   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_ALU     = 2'd1;
   localparam logic [1:0] FWD_WB      = 2'd2;

   typedef enum logic {
      StIdle,
      StBusy
   } ctrl_state_t;

   // Producer age 1 sits in the ALU output, age 2 in the writeback latch.
   function automatic logic [1:0] age_to_sel(input int unsigned age);
      logic [1:0] sel;
      case (age)
         1:       sel = FWD_ALU;
         2:       sel = FWD_WB;
         default: sel = 2'(age);
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/alu_hazard_tracker.sv
// ---------------------------------------------------------------------------
// alu_hazard_tracker
// Shift register of in-flight register writes, indexed by age 1..PIPE_DEPTH,
// plus a youngest-match search per source operand.
// Ports:
//   i_clk, i_reset      : clock, asynchronous active-low reset
//   i_shift             : advance all entries by one age (global enable)
//   i_load_we/_adr      : entry loaded into age 1 on a shift
//   i_srcA_adr, i_useA  : operand A address and read flag
//   i_srcB_adr, i_useB  : operand B address and read flag
//   o_stallA/o_selA     : A hazard needs a stall / forwarding select
//   o_stallB/o_selB     : same for B
// ---------------------------------------------------------------------------
module alu_hazard_tracker
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned FWD_STAGES = 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_shift,
   input  logic       i_load_we,
   input  logic [2:0] i_load_adr,
   input  logic [2:0] i_srcA_adr,
   input  logic       i_useA,
   input  logic [2:0] i_srcB_adr,
   input  logic       i_useB,
   output logic       o_stallA,
   output logic [1:0] o_selA,
   output logic       o_stallB,
   output logic [1:0] o_selB
);

   // Index i holds age i+1.
   logic [PIPE_DEPTH-1:0] r_vld;
   logic [2:0]            r_adr [PIPE_DEPTH];

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_vld <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            r_adr[i] <= '0;
         end
      end else if (i_shift) begin
         r_vld    <= {r_vld[PIPE_DEPTH-2:0], i_load_we};
         r_adr[0] <= i_load_adr;
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_adr[i] <= r_adr[i-1];
         end
      end
   end

   always_comb begin
      int unsigned w_age_a;
      int unsigned w_age_b;
      w_age_a  = 0;
      w_age_b  = 0;
      o_stallA = 1'b0;
      o_stallB = 1'b0;
      o_selA   = FWD_REGFILE;
      o_selB   = FWD_REGFILE;

      // Scan oldest to youngest so the youngest match is the one kept.
      for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
         if (r_vld[i] && (r_adr[i] == i_srcA_adr)) w_age_a = i + 1;
         if (r_vld[i] && (r_adr[i] == i_srcB_adr)) w_age_b = i + 1;
      end

      if (i_useA && (w_age_a != 0)) begin
         if (w_age_a <= FWD_STAGES) o_selA = age_to_sel(w_age_a);
         else                       o_stallA = 1'b1;
      end
      if (i_useB && (w_age_b != 0)) begin
         if (w_age_b <= FWD_STAGES) o_selB = age_to_sel(w_age_b);
         else                       o_stallB = 1'b1;
      end
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Issue and hazard controller between decode and alu_stage. Accepts one
// instruction per cycle, forwards operands from in-flight producers, stalls
// on unforwardable RAW hazards and while a multi-cycle op occupies the ALU.
// Ports:
//   i_clk, i_reset (async, active-low), i_enable (0 freezes all state)
//   i_dec_*            : decoded instruction and valid; o_dec_ready accepts it
//   o_issue_*          : registered instruction presented to alu_stage
//   o_fwdA/B_sel       : registered forwarding selects (0 rf, 1 ALU, 2 WB)
//   o_alu_hold         : registered, alu_stage holds its result register
// ---------------------------------------------------------------------------
module alu_issue_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned      PIPE_DEPTH = 3,
   parameter int unsigned      FWD_STAGES = 2,
   parameter logic [COP_W-1:0] MUL_COP    = MUL_COP_DEF,
   parameter int unsigned      MUL_CYCLES = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enable,
   input  logic             i_dec_valid,
   output logic             o_dec_ready,
   input  logic [COP_W-1:0] i_dec_cop,
   input  logic [2:0]       i_dec_destReg_adr,
   input  logic             i_dec_we,
   input  logic [2:0]       i_dec_regA_adr,
   input  logic [2:0]       i_dec_regB_adr,
   input  logic             i_dec_useA,
   input  logic             i_dec_useB,
   output logic             o_issue_valid,
   output logic [COP_W-1:0] o_issue_cop,
   output logic [2:0]       o_issue_destReg_adr,
   output logic             o_issue_we,
   output logic [1:0]       o_fwdA_sel,
   output logic [1:0]       o_fwdB_sel,
   output logic             o_alu_hold
);

   localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);

   ctrl_state_t      r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_mul_we, w_mul_we_nxt;
   logic [2:0]       r_mul_dest, w_mul_dest_nxt;
   logic             r_hold, w_hold_nxt;

   logic             r_issue_valid, w_issue_valid_nxt;
   logic [COP_W-1:0] r_issue_cop, w_issue_cop_nxt;
   logic [2:0]       r_issue_dest, w_issue_dest_nxt;
   logic             r_issue_we, w_issue_we_nxt;
   logic [1:0]       r_selA, w_selA_nxt;
   logic [1:0]       r_selB, w_selB_nxt;

   logic             w_stallA, w_stallB;
   logic [1:0]       w_selA, w_selB;
   logic             w_accept, w_is_mul;
   logic             w_trk_we;
   logic [2:0]       w_trk_adr;

   alu_hazard_tracker #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .FWD_STAGES (FWD_STAGES)
   ) u_tracker (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_shift    (i_enable),
      .i_load_we  (w_trk_we),
      .i_load_adr (w_trk_adr),
      .i_srcA_adr (i_dec_regA_adr),
      .i_useA     (i_dec_useA),
      .i_srcB_adr (i_dec_regB_adr),
      .i_useB     (i_dec_useB),
      .o_stallA   (w_stallA),
      .o_selA     (w_selA),
      .o_stallB   (w_stallB),
      .o_selB     (w_selB)
   );

   assign o_dec_ready = i_reset && i_enable && (r_state == StIdle) && !w_stallA && !w_stallB;
   assign w_accept    = i_dec_valid && o_dec_ready;
   assign w_is_mul    = (i_dec_cop == MUL_COP);

   always_comb begin
      w_state_nxt       = r_state;
      w_cnt_nxt         = r_cnt;
      w_mul_we_nxt      = r_mul_we;
      w_mul_dest_nxt    = r_mul_dest;
      w_hold_nxt        = r_hold;
      // A MUL's write is deferred until the op leaves the ALU.
      w_trk_we          = w_accept && !w_is_mul && i_dec_we;
      w_trk_adr         = i_dec_destReg_adr;

      w_issue_valid_nxt = w_accept;
      w_issue_we_nxt    = w_accept && i_dec_we;
      w_issue_cop_nxt   = r_issue_cop;
      w_issue_dest_nxt  = r_issue_dest;
      w_selA_nxt        = r_selA;
      w_selB_nxt        = r_selB;

      if (w_accept) begin
         w_issue_cop_nxt  = i_dec_cop;
         w_issue_dest_nxt = i_dec_destReg_adr;
         w_selA_nxt       = w_selA;
         w_selB_nxt       = w_selB;
      end

      unique case (r_state)
         StIdle: begin
            if (w_accept && w_is_mul) begin
               w_state_nxt    = StBusy;
               w_cnt_nxt      = CNT_W'(MUL_CYCLES - 1);
               w_mul_we_nxt   = i_dec_we;
               w_mul_dest_nxt = i_dec_destReg_adr;
               w_hold_nxt     = 1'b1;
            end
         end
         StBusy: begin
            if (r_cnt == CNT_W'(1)) begin
               w_state_nxt = StIdle;
               w_hold_nxt  = 1'b0;
               w_trk_we    = r_mul_we;
               w_trk_adr   = r_mul_dest;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_mul_we      <= 1'b0;
         r_mul_dest    <= '0;
         r_hold        <= 1'b0;
         r_issue_valid <= 1'b0;
         r_issue_cop   <= '0;
         r_issue_dest  <= '0;
         r_issue_we    <= 1'b0;
         r_selA        <= FWD_REGFILE;
         r_selB        <= FWD_REGFILE;
      end else if (i_enable) begin
         r_state       <= w_state_nxt;
         r_cnt         <= w_cnt_nxt;
         r_mul_we      <= w_mul_we_nxt;
         r_mul_dest    <= w_mul_dest_nxt;
         r_hold        <= w_hold_nxt;
         r_issue_valid <= w_issue_valid_nxt;
         r_issue_cop   <= w_issue_cop_nxt;
         r_issue_dest  <= w_issue_dest_nxt;
         r_issue_we    <= w_issue_we_nxt;
         r_selA        <= w_selA_nxt;
         r_selB        <= w_selB_nxt;
      end
   end

   assign o_issue_valid       = r_issue_valid;
   assign o_issue_cop         = r_issue_cop;
   assign o_issue_destReg_adr = r_issue_dest;
   assign o_issue_we          = r_issue_we;
   assign o_fwdA_sel          = r_selA;
   assign o_fwdB_sel          = r_selB;
   assign o_alu_hold          = r_hold;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Directed scenarios plus randomized traffic against a timestamp-based model:
// each tracked write carries the enabled-cycle index at which it becomes
// age 1, so producer age is simply (current index - timestamp).
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;
   import alu_ctrl_pkg::*;

   localparam int PIPE_DEPTH = 3;
   localparam int FWD_STAGES = 2;
   localparam int MUL_CYCLES = 4;
   localparam logic [3:0] MUL_OP = 4'b0110;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic       dv = 1'b0;
   logic [3:0] dcop = '0;
   logic [2:0] ddest = '0;
   logic       dwe = 1'b0;
   logic [2:0] dra = '0;
   logic [2:0] drb = '0;
   logic       dua = 1'b0;
   logic       dub = 1'b0;

   logic       ready;
   logic       iv;
   logic [3:0] icop;
   logic [2:0] idest;
   logic       iwe;
   logic [1:0] sela;
   logic [1:0] selb;
   logic       hold;
   logic [13:0] obs;

   always #5 clk = ~clk;

   alu_issue_ctrl #(
      .PIPE_DEPTH (PIPE_DEPTH),
      .FWD_STAGES (FWD_STAGES),
      .MUL_COP    (MUL_OP),
      .MUL_CYCLES (MUL_CYCLES)
   ) dut (
      .i_clk               (clk),
      .i_reset             (rst_n),
      .i_enable            (en),
      .i_dec_valid         (dv),
      .o_dec_ready         (ready),
      .i_dec_cop           (dcop),
      .i_dec_destReg_adr   (ddest),
      .i_dec_we            (dwe),
      .i_dec_regA_adr      (dra),
      .i_dec_regB_adr      (drb),
      .i_dec_useA          (dua),
      .i_dec_useB          (dub),
      .o_issue_valid       (iv),
      .o_issue_cop         (icop),
      .o_issue_destReg_adr (idest),
      .o_issue_we          (iwe),
      .o_fwdA_sel          (sela),
      .o_fwdB_sel          (selb),
      .o_alu_hold          (hold)
   );

   assign obs = {iv, icop, idest, iwe, sela, selb, hold};

   int n_cmp = 0;
   int n_bad = 0;

   // ---------------- reference model ----------------
   int         ecnt;
   int         wr_ts[$];
   logic [2:0] wr_adr[$];
   bit         mul_act;
   int         mul_t;
   logic       m_ready, m_stA, m_stB;
   logic [1:0] m_selA, m_selB;
   logic       e_valid, e_we;
   logic [3:0] e_cop;
   logic [2:0] e_dest;
   logic [1:0] e_selA, e_selB;

   function automatic bit m_busy();
      return mul_act && ((ecnt - mul_t) < MUL_CYCLES);
   endfunction

   function automatic logic [13:0] exp_vec();
      return {e_valid, e_cop, e_dest, e_we, e_selA, e_selB, m_busy()};
   endfunction

   function automatic void src_lookup(input logic [2:0] adr, input logic use_it,
                                      output logic stall, output logic [1:0] sel);
      int best;
      best  = 0;
      stall = 1'b0;
      sel   = 2'd0;
      if (use_it) begin
         foreach (wr_ts[i]) begin
            int age;
            age = ecnt - wr_ts[i];
            if (wr_adr[i] == adr && age >= 1 && age <= PIPE_DEPTH && (best == 0 || age < best))
               best = age;
         end
         if (best != 0) begin
            if (best <= FWD_STAGES) sel = 2'(best);
            else                    stall = 1'b1;
         end
      end
   endfunction

   task automatic model_reset();
      wr_ts.delete();
      wr_adr.delete();
      mul_act = 0;
      mul_t   = 0;
      ecnt    = 0;
      e_valid = 0; e_we = 0; e_cop = '0; e_dest = '0; e_selA = '0; e_selB = '0;
   endtask

   task automatic model_eval();
      src_lookup(dra, dua, m_stA, m_selA);
      src_lookup(drb, dub, m_stB, m_selB);
      m_ready = rst_n && en && !m_busy() && !m_stA && !m_stB;
   endtask

   task automatic model_edge();
      bit acc;
      if (rst_n && en) begin
         acc     = dv && m_ready;
         e_valid = acc;
         e_we    = acc && dwe;
         if (acc) begin
            e_cop  = dcop;
            e_dest = ddest;
            e_selA = m_selA;
            e_selB = m_selB;
            if (dwe) begin
               wr_ts.push_back((dcop == MUL_OP) ? ecnt + MUL_CYCLES - 1 : ecnt);
               wr_adr.push_back(ddest);
            end
            if (dcop == MUL_OP) begin
               mul_act = 1;
               mul_t   = ecnt;
            end
         end
         ecnt++;
         while (wr_ts.size() > 0 && (ecnt - wr_ts[0]) > PIPE_DEPTH) begin
            void'(wr_ts.pop_front());
            void'(wr_adr.pop_front());
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic v, input logic [3:0] c, input logic [2:0] d, input logic w,
                        input logic [2:0] a, input logic [2:0] b, input logic ua,
                        input logic ub);
      dv = v; dcop = c; ddest = d; dwe = w; dra = a; drb = b; dua = ua; dub = ub;
   endtask

   task automatic settle();
      #1;
      model_eval();
   endtask

   task automatic clk_edge();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      drive(0, 4'h0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
      for (int i = 0; i < n; i++) begin
         settle();
         clk_edge();
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b1;
      model_reset();
      drive(0, 4'h0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      settle();
      n_cmp++;
      if (obs !== 14'h0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want 0", obs);
      end
      n_cmp++;
      if (ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready: got %b want 0", ready);
      end
      rst_n = 1'b1;
      settle();
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL release_ready: got %b want 1", ready);
      end
      clk_edge();
      n_cmp++;
      if (obs !== 14'h0 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL release_outputs: got %h want %h", obs, exp_vec());
      end
   endtask

   task automatic test_back_to_back();
      drive(1, 4'h0, 3'd1, 1, 3'd2, 3'd3, 1, 1);
      settle();
      n_cmp++;
      if (ready !== 1'b1 || ready !== m_ready) begin
         n_bad++; $display("FAIL b2b_add_ready: got %b want 1", ready);
      end
      clk_edge();
      n_cmp++;
      if (obs !== exp_vec() || iv !== 1'b1) begin
         n_bad++; $display("FAIL b2b_add_issue: got %h want %h", obs, exp_vec());
      end
      drive(1, 4'h1, 3'd4, 1, 3'd1, 3'd1, 1, 1);
      settle();
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL b2b_sub_ready: got %b want 1", ready);
      end
      clk_edge();
      n_cmp++;
      if ({sela, selb} !== 4'b0101 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL b2b_sub_fwd: got %h want %h (sels 1/1)", obs, exp_vec());
      end
      idle(PIPE_DEPTH + 1);
   endtask

   task automatic test_age3();
      drive(1, 4'h0, 3'd1, 1, 3'd6, 3'd7, 1, 1);
      settle();
      clk_edge();
      for (int i = 0; i < 2; i++) begin
         drive(1, 4'h0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
         settle();
         clk_edge();
      end
      drive(1, 4'h2, 3'd3, 1, 3'd1, 3'd0, 1, 0);
      settle();
      n_cmp++;
      if (ready !== 1'b0 || m_ready !== 1'b0) begin
         n_bad++; $display("FAIL age3_stall: got %b want 0", ready);
      end
      clk_edge();
      n_cmp++;
      if (iv !== 1'b0 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL age3_bubble: got %h want %h", obs, exp_vec());
      end
      settle();
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL age3_release: got %b want 1", ready);
      end
      clk_edge();
      n_cmp++;
      if (iv !== 1'b1 || sela !== 2'd0 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL age3_issue: got %h want %h (selA 0)", obs, exp_vec());
      end
      idle(PIPE_DEPTH + 1);
   endtask

   task automatic test_youngest();
      drive(1, 4'h0, 3'd2, 1, 3'd5, 3'd6, 0, 0);
      settle();
      clk_edge();
      settle();
      clk_edge();
      drive(1, 4'h3, 3'd7, 0, 3'd2, 3'd0, 1, 0);
      settle();
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL youngest_ready: got %b want 1", ready);
      end
      clk_edge();
      n_cmp++;
      if (sela !== 2'd1 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL youngest_sel: got %h want %h (selA 1)", obs, exp_vec());
      end
      idle(1);
      // Remaining r2 write is now age 3: a used read would stall.
      drive(1, 4'h3, 3'd7, 0, 3'd2, 3'd0, 0, 0);
      settle();
      n_cmp++;
      if (ready !== 1'b1) begin
         n_bad++; $display("FAIL unused_nostall: got %b want 1", ready);
      end
      clk_edge();
      n_cmp++;
      if (sela !== 2'd0 || iv !== 1'b1 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL unused_sel: got %h want %h", obs, exp_vec());
      end
      idle(PIPE_DEPTH + 1);
   endtask

   task automatic test_mul();
      drive(1, MUL_OP, 3'd5, 1, 3'd0, 3'd0, 0, 0);
      settle();
      clk_edge();
      drive(1, 4'h0, 3'd6, 1, 3'd5, 3'd0, 1, 0);
      for (int i = 0; i < MUL_CYCLES - 1; i++) begin
         settle();
         n_cmp++;
         if (ready !== 1'b0 || hold !== 1'b1) begin
            n_bad++; $display("FAIL mul_busy[%0d]: ready %b hold %b want 0/1", i, ready, hold);
         end
         clk_edge();
      end
      settle();
      n_cmp++;
      if (ready !== 1'b1 || hold !== 1'b0) begin
         n_bad++; $display("FAIL mul_done: ready %b hold %b want 1/0", ready, hold);
      end
      clk_edge();
      n_cmp++;
      if (sela !== 2'd1 || iv !== 1'b1 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL mul_fwd: got %h want %h (selA 1)", obs, exp_vec());
      end
      idle(PIPE_DEPTH + 1);
   endtask

   task automatic test_mul_enable();
      int hcnt;
      hcnt = 0;
      drive(1, MUL_OP, 3'd5, 1, 3'd0, 3'd0, 0, 0);
      settle();
      clk_edge();
      drive(0, 4'h0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
      for (int i = 0; i < 8; i++) begin
         en = (i == 1 || i == 2) ? 1'b0 : 1'b1;
         settle();
         if (hold === 1'b1) hcnt++;
         n_cmp++;
         if (obs !== exp_vec() || ready !== m_ready) begin
            n_bad++; $display("FAIL mul_en[%0d]: got %h/%b want %h/%b", i, obs, ready, exp_vec(),
                              m_ready);
         end
         clk_edge();
      end
      en = 1'b1;
      n_cmp++;
      if (hcnt != 5) begin
         n_bad++; $display("FAIL mul_en_holdlen: got %0d want 5", hcnt);
      end
      idle(PIPE_DEPTH + 1);
   endtask

   task automatic test_mul_reset();
      drive(1, MUL_OP, 3'd5, 1, 3'd0, 3'd0, 0, 0);
      settle();
      clk_edge();
      drive(0, 4'h0, 3'd0, 0, 3'd0, 3'd0, 0, 0);
      settle();
      clk_edge();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (obs !== 14'h0 || ready !== 1'b0) begin
         n_bad++; $display("FAIL mulrst_outputs: got %h/%b want 0/0", obs, ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 4'h0, 3'd6, 1, 3'd5, 3'd0, 1, 0);
      for (int i = 0; i < MUL_CYCLES; i++) begin
         settle();
         n_cmp++;
         if (ready !== 1'b1 || hold !== 1'b0) begin
            n_bad++; $display("FAIL mulrst_ready[%0d]: ready %b hold %b want 1/0", i, ready, hold);
         end
         clk_edge();
         drive(1, 4'h0, 3'd6, 0, 3'd5, 3'd0, 1, 0);
      end
      n_cmp++;
      if (sela !== 2'd0 || obs !== exp_vec()) begin
         n_bad++; $display("FAIL mulrst_nofwd: got %h want %h (selA 0)", obs, exp_vec());
      end
      idle(PIPE_DEPTH + 1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [3:0] c;
         en = ($urandom_range(0, 9) != 0);
         c  = ($urandom_range(0, 5) == 0) ? MUL_OP : 4'($urandom_range(0, 15));
         drive($urandom_range(0, 3) != 0, c, 3'($urandom_range(0, 3)), 1'($urandom),
               3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
         settle();
         n_cmp++;
         if (ready !== m_ready) begin
            n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, ready, m_ready);
         end
         clk_edge();
         n_cmp++;
         if (obs !== exp_vec()) begin
            n_bad++; $display("FAIL rand_regs[%0d]: got %h want %h", i, obs, exp_vec());
         end
      end
      en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_age3();
      test_youngest();
      test_mul();
      test_mul_enable();
      test_mul_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue and hazard controller between the decode stage and alu_stage.
- Accepts one decoded ALU instruction per cycle over a valid/ready handshake.
- Tracks in-flight register writes and drives per-operand forwarding selects.
- Stalls decode on unforwardable RAW hazards and while a multi-cycle op holds the ALU.

Parameters:
PIPE_DEPTH, 3, cycles from issue handshake to register-file write completion (tracker depth)
FWD_STAGES, 2, producer ages 1..FWD_STAGES are forwardable; older in-flight ages stall
MUL_COP, 4'b0110, cop value executed as a multi-cycle operation
MUL_CYCLES, 4, total ALU occupancy of a MUL_COP instruction (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  global stage enable; 0 freezes all state
dec_valid  in  1  decode presents an instruction
dec_ready  out  1  controller accepts it this cycle (combinational)
dec_cop  in  4  operation code
dec_destReg_adr  in  3  destination register
dec_we  in  1  instruction writes destReg
dec_regA_adr  in  3  source A address
dec_regB_adr  in  3  source B address
dec_useA  in  1  source A is read
dec_useB  in  1  source B is read
issue_valid  out  1  registered: instruction presented to alu_stage
issue_cop  out  4  registered cop
issue_destReg_adr  out  3  registered destination
issue_we  out  1  registered write enable (0 when issue_valid=0)
fwdA_sel  out  2  registered: 0 regfile, 1 ALU output, 2 writeback latch
fwdB_sel  out  2  same for B
alu_hold  out  1  registered: alu_stage must hold its result register (multi-cycle op)

Behaviour:
- Reset (reset=0, async): FSM=IDLE, tracker cleared, all registered outputs 0; dec_ready=0 while in reset.
- enable=0: no state change, dec_ready=0; registered outputs keep their values.
- Handshake: accept when dec_valid && dec_ready on a rising edge. Issue outputs update on that same edge, giving 1-cycle latency. Otherwise issue_valid=0, issue_we=0, other outputs hold.
- Tracker: PIPE_DEPTH entries {valid, adr}, indexed by age 1..PIPE_DEPTH. Shifts every enabled cycle. Age 1 is loaded with {dec_we, dec_destReg_adr} on an accepted non-MUL handshake, otherwise {0,x}. Entries older than PIPE_DEPTH are dropped.
- Hazard per used source: find the youngest valid entry whose adr matches the source address.
  - No match: sel=0.
  - Age k <= FWD_STAGES: sel=k.
  - Age k > FWD_STAGES: stall.
- An unused source never stalls; its sel is 0. Either operand stalling forces dec_ready=0. R0 is an ordinary register.
- FSM states IDLE, BUSY:
  - IDLE: dec_ready = !stall.
  - Accepting cop==MUL_COP in IDLE moves to BUSY. A counter loads MUL_CYCLES-1, the dest/we are latched, and alu_hold=1 from the next cycle.
  - BUSY: dec_ready=0. The counter decrements each enabled cycle.
  - When the counter reaches 1, the latched {we, dest} loads tracker age 1 on the next shift, alu_hold clears and the FSM returns to IDLE.
  - A MUL is therefore forwardable from the first cycle after BUSY ends.
- Simultaneous match of A and B to different ages: each sel is resolved independently.
- Back-to-back MULs: the second MUL is accepted only in IDLE.
- Reset asserted mid-BUSY aborts the op; the MUL's write is never tracked.

Decomposition:
- Package alu_ctrl_pkg: FWD_REGFILE=0, FWD_ALU=1, FWD_WB=2 constants, FSM state typedef, cop width constant, MUL_COP default.
- Sub-module alu_hazard_tracker: shift tracker plus youngest-match search returning {stall, sel} per operand. The FSM and issue registers stay in the top module.

Test Plan:
- Reset low for 2 cycles then high, dec_valid=0 -> all outputs 0, dec_ready=1 after release.
- Back-to-back: ADD r1=r2+r3 then SUB r4=r1+r1 -> no stall; second issue fwdA_sel=fwdB_sel=1.
- Age-3 hazard: ADD r1, NOP (dec_we=0), NOP, then instr reading r1 -> dec_ready=0 for 1 cycle, then issue with sel=0.
- Youngest wins: writes to r2 at ages 2 and 1, then read r2 on A -> fwdA_sel=1. With dec_useA=0 the same read -> no stall, sel 0.
- MUL: cop=4'b0110, dest r5 -> dec_ready=0 and alu_hold=1 for 3 cycles; dependent r5 reader accepted next cycle with sel=1.
- enable=0 for 2 cycles mid-BUSY -> counter frozen, total hold extends to 5 cycles. Reset pulse mid-BUSY -> IDLE, outputs 0, no r5 forwarding.
